uart_fifo_sync: RTL and testbench

//  Parametrised single-clock byte/word FIFO between the UART rx/tx shifters and the host register interface.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_fifo_ram.sv | 26 ++
 rtl/uart_fifo_sync.sv | 113 +++++++++++
 tb/tb_uart_fifo_sync.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and width helper for the tx/rx buffer paths.
package uart_pkg;

    localparam int unsigned UART_DATA_W     = 8;
    localparam int unsigned UART_FIFO_DEPTH = 64;

    // Bits needed to index v distinct values (v >= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned x = v - 1; x > 0; x = x >> 1)
            r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = UART_DATA_W,
    parameter int unsigned DEPTH = UART_FIFO_DEPTH,
    parameter int unsigned AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_fifo_sync.sv
// Parametrised single-clock FIFO between the UART shifters and the host register interface.
module uart_fifo_sync
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH    = UART_DATA_W,
    parameter int unsigned DEPTH    = UART_FIFO_DEPTH,
    parameter int unsigned FWFT     = 0,
    parameter int unsigned AF_LEVEL = 56,
    parameter int unsigned AE_LEVEL = 8,
    parameter int unsigned CW       = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int unsigned PW = clog2(DEPTH);

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] ram_rdata;
    logic             rd_acc, wr_acc, rd_go, wr_go;

    assign empty        = (count == '0);
    assign full         = (count == CW'(DEPTH));
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | rd_acc);
    // flush swallows both requests: no transfer, no error
    assign rd_go  = rd_acc & ~flush;
    assign wr_go  = wr_acc & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_go)
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (rd_go)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(wr_go) - CW'(rd_go);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  & ~clr_err) | (wr_en & ~wr_acc & ~flush);
            underflow <= (underflow & ~clr_err) | (rd_en & ~rd_acc & ~flush);
        end
    end

    uart_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_go),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    generate
        if (FWFT != 0) begin : g_fwft
            // masked while empty so uninitialised storage never reaches the port
            assign rd_data  = empty ? '0 : ram_rdata;
            assign rd_valid = ~empty;
        end else begin : g_reg
            logic [WIDTH-1:0] rd_data_q;
            logic             rd_valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_go;
                    if (rd_go)
                        rd_data_q <= ram_rdata;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_uart_fifo_sync.sv
// Scoreboard bench for uart_fifo_sync: DEPTH=64 registered, DEPTH=5 wrap, DEPTH=4 FWFT.
module tb_uart_fifo_sync;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       wr_en [3];
    logic       rd_en [3];
    logic       flush [3];
    logic       clr_err [3];
    logic [7:0] wr_data [3];

    logic [7:0] rd_data_a [3];
    logic       rd_valid_a [3], full_a [3], empty_a [3], af_a [3], ae_a [3], ovf_a [3], unf_a [3];
    logic [6:0] cnt_a [3];
    logic [6:0] cnt0;
    logic [2:0] cnt1, cnt2;

    assign cnt_a[0] = cnt0;
    assign cnt_a[1] = {4'b0, cnt1};
    assign cnt_a[2] = {4'b0, cnt2};

    uart_fifo_sync u0 (
        .clk(clk), .rst(rst), .flush(flush[0]), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
        .rd_en(rd_en[0]), .rd_data(rd_data_a[0]), .rd_valid(rd_valid_a[0]), .full(full_a[0]),
        .empty(empty_a[0]), .almost_full(af_a[0]), .almost_empty(ae_a[0]), .count(cnt0),
        .overflow(ovf_a[0]), .underflow(unf_a[0]), .clr_err(clr_err[0])
    );

    uart_fifo_sync #(.DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) u1 (
        .clk(clk), .rst(rst), .flush(flush[1]), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
        .rd_en(rd_en[1]), .rd_data(rd_data_a[1]), .rd_valid(rd_valid_a[1]), .full(full_a[1]),
        .empty(empty_a[1]), .almost_full(af_a[1]), .almost_empty(ae_a[1]), .count(cnt1),
        .overflow(ovf_a[1]), .underflow(unf_a[1]), .clr_err(clr_err[1])
    );

    uart_fifo_sync #(.DEPTH(4), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)) u2 (
        .clk(clk), .rst(rst), .flush(flush[2]), .wr_en(wr_en[2]), .wr_data(wr_data[2]),
        .rd_en(rd_en[2]), .rd_data(rd_data_a[2]), .rd_valid(rd_valid_a[2]), .full(full_a[2]),
        .empty(empty_a[2]), .almost_full(af_a[2]), .almost_empty(ae_a[2]), .count(cnt2),
        .overflow(ovf_a[2]), .underflow(unf_a[2]), .clr_err(clr_err[2])
    );

    int total = 0;
    int bad   = 0;

    int depth [3] = '{64, 5, 4};
    int afl   [3] = '{56, 4, 3};
    int ael   [3] = '{8, 1, 1};
    int mcnt  [3] = '{0, 0, 0};
    bit movf  [3] = '{0, 0, 0};
    bit munf  [3] = '{0, 0, 0};
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic q_push(input int k, input logic [7:0] d);
        case (k)
            0: q0.push_back(d);
            1: q1.push_back(d);
            default: q2.push_back(d);
        endcase
    endtask

    task automatic q_pop(input int k, output logic [7:0] d);
        case (k)
            0: d = q0.pop_front();
            1: d = q1.pop_front();
            default: d = q2.pop_front();
        endcase
    endtask

    task automatic q_front(input int k, output logic [7:0] d);
        case (k)
            0: d = q0[0];
            1: d = q1[0];
            default: d = q2[0];
        endcase
    endtask

    task automatic q_clear(input int k);
        case (k)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_status(input int k);
        logic [7:0] head;
        check_eq($sformatf("i%0d count", k), {25'b0, cnt_a[k]}, mcnt[k]);
        check_eq($sformatf("i%0d full", k), full_a[k], mcnt[k] == depth[k]);
        check_eq($sformatf("i%0d empty", k), empty_a[k], mcnt[k] == 0);
        check_eq($sformatf("i%0d almost_full", k), af_a[k], mcnt[k] >= afl[k]);
        check_eq($sformatf("i%0d almost_empty", k), ae_a[k], mcnt[k] <= ael[k]);
        check_eq($sformatf("i%0d overflow", k), ovf_a[k], movf[k]);
        check_eq($sformatf("i%0d underflow", k), unf_a[k], munf[k]);
        if (k == 2) begin
            check_eq("i2 fwft rd_valid", rd_valid_a[2], mcnt[2] > 0);
            if (mcnt[2] > 0) begin
                q_front(2, head);
                check_eq("i2 fwft head", rd_data_a[2], head);
            end
        end
    endtask

    task automatic op(input int k, input bit w, input logic [7:0] d, input bit r);
        bit racc, wacc;
        logic [7:0] exp_rd;
        exp_rd = '0;
        racc = r && (mcnt[k] > 0);
        wacc = w && ((mcnt[k] < depth[k]) || racc);
        if (racc) q_pop(k, exp_rd);
        if (wacc) q_push(k, d);
        if (w && !wacc) movf[k] = 1'b1;
        if (r && !racc) munf[k] = 1'b1;
        mcnt[k] = mcnt[k] + int'(wacc) - int'(racc);
        wr_en[k] = w; wr_data[k] = d; rd_en[k] = r;
        tick();
        wr_en[k] = 1'b0; rd_en[k] = 1'b0;
        check_status(k);
        if (k != 2) begin
            check_eq($sformatf("i%0d rd_valid", k), rd_valid_a[k], racc);
            if (racc) check_eq($sformatf("i%0d rd_data", k), rd_data_a[k], exp_rd);
        end
    endtask

    task automatic do_clr(input int k);
        clr_err[k] = 1'b1;
        movf[k] = 1'b0; munf[k] = 1'b0;
        tick();
        clr_err[k] = 1'b0;
        check_status(k);
    endtask

    task automatic do_flush(input int k);
        flush[k] = 1'b1; wr_en[k] = 1'b1; rd_en[k] = 1'b1; wr_data[k] = 8'h77;
        mcnt[k] = 0;
        q_clear(k);
        tick();
        flush[k] = 1'b0; wr_en[k] = 1'b0; rd_en[k] = 1'b0;
        check_status(k);
        if (k != 2) check_eq($sformatf("i%0d flush rd_valid", k), rd_valid_a[k], 1'b0);
    endtask

    initial begin
        logic [7:0] seq;
        for (int i = 0; i < 3; i++) begin
            wr_en[i] = 1'b0; rd_en[i] = 1'b0; flush[i] = 1'b0; clr_err[i] = 1'b0; wr_data[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) check_status(k);
        check_eq("i0 reset rd_data", rd_data_a[0], 8'h00);
        check_eq("i0 reset rd_valid", rd_valid_a[0], 1'b0);

        // async reset mid-stream with five entries held and a read just completed
        for (int i = 0; i < 6; i++) op(0, 1'b1, 8'(8'h10 + i), 1'b0);
        op(0, 1'b0, 8'h00, 1'b1);
        check_eq("i0 pre-reset count", {25'b0, cnt_a[0]}, 5);
        #2 rst = 1'b1;
        #1;
        mcnt[0] = 0; q_clear(0);
        check_status(0);
        check_eq("i0 async rst rd_valid", rd_valid_a[0], 1'b0);
        check_eq("i0 async rst rd_data", rd_data_a[0], 8'h00);
        tick();
        #2 rst = 1'b0;
        tick();

        // fill, overflow, full read+write, drain, underflow, empty read+write
        for (int i = 0; i < 64; i++) op(0, 1'b1, 8'(i), 1'b0);
        op(0, 1'b1, 8'hEE, 1'b0);
        op(0, 1'b1, 8'hA5, 1'b1);
        do_clr(0);
        while (mcnt[0] > 0) op(0, 1'b0, 8'h00, 1'b1);
        op(0, 1'b0, 8'h00, 1'b1);
        do_clr(0);
        op(0, 1'b1, 8'h5A, 1'b1);
        op(0, 1'b0, 8'h00, 1'b1);
        do_clr(0);

        // non-power-of-two depth: pointers wrap 4 -> 0 repeatedly
        seq = 8'h00;
        op(1, 1'b1, seq, 1'b0); seq++;
        op(1, 1'b1, seq, 1'b0); seq++;
        for (int b = 0; b < 20; b++) begin
            for (int j = 0; j < 3; j++) begin op(1, 1'b1, seq, 1'b0); seq++; end
            for (int j = 0; j < 3; j++) op(1, 1'b0, 8'h00, 1'b1);
        end
        op(1, 1'b1, seq, 1'b0); seq++;
        op(1, 1'b1, seq, 1'b0); seq++;
        op(1, 1'b1, seq, 1'b0);
        op(1, 1'b1, 8'hFF, 1'b0);
        do_flush(1);

        // first-word-fall-through
        op(2, 1'b1, 8'h3C, 1'b0);
        op(2, 1'b1, 8'h3D, 1'b0);
        op(2, 1'b0, 8'h00, 1'b1);
        op(2, 1'b1, 8'h3E, 1'b1);
        do_flush(2);
        op(2, 1'b0, 8'h00, 1'b1);
        do_clr(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
